// File: rtl/rtsnoc_pkg.sv
// Shared constants and FSM state types for the RTSNoC local-port arbiter.
package rtsnoc_pkg;

    localparam int unsigned FLIT_W     = 38;
    localparam int unsigned RX_SEL_LSB = 32;

    typedef enum logic {
        TX_IDLE,
        TX_SEND
    } tx_state_t;

    typedef enum logic {
        RX_IDLE,
        RX_GAP
    } rx_state_t;

endpackage

// File: rtl/rtsnoc_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr, wrapping.
module rtsnoc_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned SEL_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [SEL_W-1:0]   idx,
    output logic               valid
);
    import rtsnoc_pkg::*;

    logic [SEL_W-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = SEL_W'((32'(ptr) + i) % NUM_REQ);
            if (!valid && req[cand]) begin
                valid       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/rtsnoc_local_port_arbiter.sv
// Shares one RTSNoC router local port between NUM_REQ requesters:
// round-robin registered TX path, RX steering into per-requester single-flit holding registers.
module rtsnoc_local_port_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned SEL_W      = 2,
    parameter int unsigned FLIT_W     = rtsnoc_pkg::FLIT_W,
    parameter int unsigned RX_SEL_LSB = rtsnoc_pkg::RX_SEL_LSB
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_REQ*FLIT_W-1:0] req_din_i,
    input  logic [NUM_REQ-1:0]        req_wr_i,
    output logic [NUM_REQ-1:0]        req_ack_o,
    output logic [NUM_REQ*FLIT_W-1:0] req_dout_o,
    output logic [NUM_REQ-1:0]        req_nd_o,
    input  logic [NUM_REQ-1:0]        req_rd_i,
    output logic [FLIT_W-1:0]         noc_din_o,
    output logic                      noc_wr_o,
    input  logic                      noc_wait_i,
    input  logic [FLIT_W-1:0]         noc_dout_i,
    input  logic                      noc_nd_i,
    output logic                      noc_rd_o
);
    import rtsnoc_pkg::*;

    tx_state_t          tx_state;
    rx_state_t          rx_state;
    logic [SEL_W-1:0]   rr_ptr;
    logic [SEL_W-1:0]   rr_next;
    logic [NUM_REQ-1:0] pend;
    logic [NUM_REQ-1:0] arb_grant;
    logic [SEL_W-1:0]   arb_idx;
    logic               arb_valid;
    logic [FLIT_W-1:0]  sel_flit;
    logic               tx_load;

    logic [SEL_W-1:0]   rx_sel;
    logic               rx_in_range;
    logic               rx_take;
    logic               rx_fill;

    // A requester acked this cycle still shows req_wr; keep it out of this grant.
    assign pend = req_wr_i & ~req_ack_o;

    rtsnoc_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .SEL_W   (SEL_W)
    ) u_arb (
        .req   (pend),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    always_comb begin
        sel_flit = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (arb_grant[k]) sel_flit = req_din_i[k*FLIT_W +: FLIT_W];
        end
    end

    assign rr_next = (32'(arb_idx) == NUM_REQ - 1) ? '0 : arb_idx + SEL_W'(1);
    assign tx_load = arb_valid && ((tx_state == TX_IDLE) || !noc_wait_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_state  <= TX_IDLE;
            noc_wr_o  <= 1'b0;
            noc_din_o <= '0;
            req_ack_o <= '0;
            rr_ptr    <= '0;
        end else begin
            req_ack_o <= '0;
            if (tx_load) begin
                noc_din_o <= sel_flit;
                noc_wr_o  <= 1'b1;
                req_ack_o <= arb_grant;
                rr_ptr    <= rr_next;
                tx_state  <= TX_SEND;
            end else if (tx_state == TX_SEND && !noc_wait_i) begin
                noc_wr_o <= 1'b0;
                tx_state <= TX_IDLE;
            end
        end
    end

    assign rx_sel      = noc_dout_i[RX_SEL_LSB +: SEL_W];
    assign rx_in_range = 32'(rx_sel) < NUM_REQ;
    // Out-of-range targets are popped and dropped; a full target stalls the router head.
    assign rx_take     = (rx_state == RX_IDLE) && noc_nd_i && !(rx_in_range && req_nd_o[rx_sel]);
    assign rx_fill     = rx_take && rx_in_range;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_state   <= RX_IDLE;
            noc_rd_o   <= 1'b0;
            req_nd_o   <= '0;
            req_dout_o <= '0;
        end else begin
            noc_rd_o <= rx_take;
            rx_state <= rx_take ? RX_GAP : RX_IDLE;
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                if (rx_fill && rx_sel == SEL_W'(k)) begin
                    req_nd_o[k]                     <= 1'b1;
                    req_dout_o[k*FLIT_W +: FLIT_W] <= noc_dout_i;
                end else if (req_rd_i[k]) begin
                    req_nd_o[k] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_rtsnoc_local_port_arbiter.sv
// Bench for rtsnoc_local_port_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_rtsnoc_local_port_arbiter;
    localparam int N = 4;
    localparam int W = 38;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] req_din;
    logic [N-1:0]   req_wr;
    logic [N-1:0]   req_ack_o;
    logic [N*W-1:0] req_dout_o;
    logic [N-1:0]   req_nd_o;
    logic [N-1:0]   req_rd;
    logic [W-1:0]   noc_din_o;
    logic           noc_wr_o;
    logic           noc_wait;
    logic [W-1:0]   noc_dout;
    logic           noc_nd;
    logic           noc_rd_o;

    always #5 clk = ~clk;

    rtsnoc_local_port_arbiter #(
        .NUM_REQ    (N),
        .SEL_W      (2),
        .FLIT_W     (W),
        .RX_SEL_LSB (32)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_din_i  (req_din),
        .req_wr_i   (req_wr),
        .req_ack_o  (req_ack_o),
        .req_dout_o (req_dout_o),
        .req_nd_o   (req_nd_o),
        .req_rd_i   (req_rd),
        .noc_din_o  (noc_din_o),
        .noc_wr_o   (noc_wr_o),
        .noc_wait_i (noc_wait),
        .noc_dout_i (noc_dout),
        .noc_nd_i   (noc_nd),
        .noc_rd_o   (noc_rd_o)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    // Behavioural model: "busy" flag with current flit, rotating priority, router FIFO, holding slots.
    bit           m_wr = 0;
    logic [W-1:0] m_din = '0;
    logic [N-1:0] m_ack = '0;
    int           m_ptr = 0;
    bit           m_rd = 0;
    logic [N-1:0] m_hnd = '0;
    logic [W-1:0] m_hd [N];
    logic [W-1:0] rq [$];

    logic [N-1:0] t_pend, t_hnd;
    logic [1:0]   t_k;
    int           t_g, t_j;
    bit           t_rd;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        t_rd  = 0;
        t_hnd = m_hnd;
        for (int k = 0; k < N; k++) if (req_rd[k]) t_hnd[k] = 1'b0;
        if (!m_rd && noc_nd) begin
            t_k = noc_dout[33:32];
            if (!m_hnd[t_k]) begin
                t_rd       = 1;
                t_hnd[t_k] = 1'b1;
                m_hd[t_k]  = noc_dout;
            end
        end
        if (m_rd && rq.size() > 0) void'(rq.pop_front());
        if (rst) begin
            m_wr  = 0;
            m_din = '0;
            m_ack = '0;
            m_ptr = 0;
            m_rd  = 0;
            m_hnd = '0;
            for (int k = 0; k < N; k++) m_hd[k] = '0;
        end else begin
            if (!m_wr || !noc_wait) begin
                t_pend = req_wr & ~m_ack;
                t_g = -1;
                for (int i = 0; i < N; i++) begin
                    t_j = (m_ptr + i) % N;
                    if (t_g < 0 && t_pend[2'(t_j)]) t_g = t_j;
                end
                if (t_g >= 0) begin
                    m_wr  = 1;
                    m_din = req_din[t_g*W +: W];
                    m_ack = 4'b0001 << t_g;
                    m_ptr = (t_g + 1) % N;
                end else begin
                    m_wr  = 0;
                    m_ack = '0;
                end
            end else begin
                m_ack = '0;
            end
            m_hnd = t_hnd;
            m_rd  = t_rd;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("noc_wr", 64'(noc_wr_o), 64'(m_wr));
            if (m_wr) check("noc_din", 64'(noc_din_o), 64'(m_din));
            check("req_ack", 64'(req_ack_o), 64'(m_ack));
            check("noc_rd", 64'(noc_rd_o), 64'(m_rd));
            check("req_nd", 64'(req_nd_o), 64'(m_hnd));
            for (int k = 0; k < N; k++)
                if (m_hnd[k]) check("req_dout", 64'(req_dout_o[k*W +: W]), 64'(m_hd[k]));
        end
    end

    task automatic drive_router();
        noc_nd   = (rq.size() != 0);
        noc_dout = (rq.size() != 0) ? rq[0] : '0;
    endtask

    task automatic push(input logic [W-1:0] f);
        rq.push_back(f);
        drive_router();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive_router();
    endtask

    function automatic logic [W-1:0] rnd_flit();
        return W'({$urandom, $urandom});
    endfunction

    int           exp_g [5] = '{0, 1, 2, 3, 0};
    logic [W-1:0] f_a, f_b;

    initial begin
        rst = 1; req_din = '0; req_wr = '0; req_rd = '0; noc_wait = 0;
        drive_router();
        step(); step();
        cmp_en = 1;
        check("rst_wr", 64'(noc_wr_o), 64'd0);
        check("rst_din", 64'(noc_din_o), 64'd0);
        check("rst_ack", 64'(req_ack_o), 64'd0);
        check("rst_rd", 64'(noc_rd_o), 64'd0);
        check("rst_nd", 64'(req_nd_o), 64'd0);
        check("rst_dout", 64'(|req_dout_o), 64'd0);
        rst = 0;

        // single TX
        req_din[2*W +: W] = 38'h0A_DEADBEEF;
        req_wr = 4'b0100;
        step();
        check("t1_wr", 64'(noc_wr_o), 64'd1);
        check("t1_din", 64'(noc_din_o), 64'h0A_DEADBEEF);
        check("t1_ack", 64'(req_ack_o), 64'b0100);
        req_wr = '0;
        step();
        check("t1_wr_off", 64'(noc_wr_o), 64'd0);
        check("t1_ack_off", 64'(req_ack_o), 64'd0);

        // round robin from a fresh pointer
        rst = 1; step(); rst = 0;
        for (int k = 0; k < N; k++) req_din[k*W +: W] = W'(k + 1);
        req_wr = 4'hF;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t2_ack", 64'(req_ack_o), 64'(4'b0001 << exp_g[i]));
            check("t2_din", 64'(noc_din_o), 64'(exp_g[i] + 1));
        end
        req_wr = '0;
        step();
        check("t2_wr_off", 64'(noc_wr_o), 64'd0);

        // wait stall
        noc_wait = 1;
        req_din[1*W +: W] = 38'h11_11112222;
        req_wr = 4'b0010;
        step();
        check("t3_ack", 64'(req_ack_o), 64'b0010);
        req_wr = 4'b0001;
        req_din[0*W +: W] = 38'h22_33334444;
        repeat (5) begin
            step();
            check("t3_hold_wr", 64'(noc_wr_o), 64'd1);
            check("t3_hold_din", 64'(noc_din_o), 64'h11_11112222);
            check("t3_hold_ack", 64'(req_ack_o), 64'd0);
        end
        noc_wait = 0;
        step();
        check("t3_next_din", 64'(noc_din_o), 64'h22_33334444);
        check("t3_next_ack", 64'(req_ack_o), 64'b0001);
        req_wr = '0;
        step();

        // RX steer
        f_a = {4'h0, 2'd3, 32'h12345678};
        push(f_a);
        step();
        check("t4_rd", 64'(noc_rd_o), 64'd1);
        check("t4_nd3", 64'(req_nd_o[3]), 64'd1);
        check("t4_dout3", 64'(req_dout_o[3*W +: W]), 64'h3_12345678);
        step();
        check("t4_rd_gap", 64'(noc_rd_o), 64'd0);
        req_rd = 4'b1000; step(); req_rd = '0;
        check("t4_pop", 64'(req_nd_o), 64'd0);

        // RX backpressure
        f_a = {4'h0, 2'd1, 32'hAAAA0001};
        f_b = {4'h0, 2'd1, 32'hBBBB0002};
        push(f_a); push(f_b);
        step();
        check("t5_rd1", 64'(noc_rd_o), 64'd1);
        check("t5_dout1", 64'(req_dout_o[1*W +: W]), 64'h1_AAAA0001);
        step();
        repeat (3) begin
            step();
            check("t5_blocked", 64'(noc_rd_o), 64'd0);
        end
        req_rd = 4'b0010;
        step();
        req_rd = '0;
        check("t5_popped", 64'(req_nd_o[1]), 64'd0);
        step();
        check("t5_rd2", 64'(noc_rd_o), 64'd1);
        check("t5_dout2", 64'(req_dout_o[1*W +: W]), 64'h1_BBBB0002);
        step();
        req_rd = 4'b0010; step(); req_rd = '0;

        // reset during TX_SEND with wait
        noc_wait = 1;
        req_din[2*W +: W] = 38'h3F_FFFF0000;
        req_wr = 4'b0100;
        push({4'h0, 2'd0, 32'hCAFEF00D});
        step();
        check("t6_wr", 64'(noc_wr_o), 64'd1);
        rst = 1;
        step();
        check("t6_rst_wr", 64'(noc_wr_o), 64'd0);
        check("t6_rst_nd", 64'(req_nd_o), 64'd0);
        check("t6_rst_ack", 64'(req_ack_o), 64'd0);
        rst = 0; noc_wait = 0;
        for (int k = 0; k < N; k++) req_din[k*W +: W] = rnd_flit();
        req_wr = 4'hF;
        step();
        check("t6_first_grant", 64'(req_ack_o), 64'b0001);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N; k++) begin
                if (req_wr[k] && m_ack[k]) begin
                    if ($urandom_range(1, 0) == 1) req_din[k*W +: W] = rnd_flit();
                    else req_wr[k] = 1'b0;
                end else if (!req_wr[k] && $urandom_range(2, 0) == 0) begin
                    req_din[k*W +: W] = rnd_flit();
                    req_wr[k] = 1'b1;
                end
                req_rd[k] = ($urandom_range(2, 0) == 0);
            end
            noc_wait = ($urandom_range(3, 0) == 0);
            rst = ($urandom_range(399, 0) == 0);
            if ($urandom_range(2, 0) == 0 && rq.size() < 4) push(rnd_flit());
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
